vga_rect_fill: RTL and testbench

- Avalon-MM rectangle-fill engine upstream of the VGA OSD controller's pixel RAM window.
- Nios programs a rectangle (X0, Y0, W, H) and a 16-bit fill word through a slave port.
- A master port then issues one write per pixel to the controller's frame-RAM address space, row-major, at address Y*H_RES+X.
- Offloads bulk clears and box drawing from the CPU.

---
 rtl/vga_fill_pkg.sv | 20 ++
 rtl/vga_fill_addr_gen.sv | 44 ++++
 rtl/vga_rect_fill.sv | 136 +++++++++++++
 tb/tb_vga_rect_fill.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fill_pkg.sv
// vga_fill_pkg: shared constants, register map and FSM states for the rectangle fill engine.
package vga_fill_pkg;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_W      = 3'd2;
    localparam logic [2:0] REG_H      = 3'd3;
    localparam logic [2:0] REG_FILL   = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERROR   = 2;
    localparam int ST_ABORTED = 3;
    localparam int ST_IRQ_EN  = 4;
    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;
endpackage

// File: rtl/vga_fill_addr_gen.sv
// vga_fill_addr_gen: row-major pixel walker; row_base accumulates H_RES per row so only
// the initial Y0*H_RES needs a multiply.
module vga_fill_addr_gen
    import vga_fill_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              accept,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
    input  logic [10:0]       w,
    input  logic [9:0]        h,
    output logic [ADDR_W-1:0] address,
    output logic              last
);
    logic [10:0]       col;
    logic [9:0]        row;
    logic [ADDR_W-1:0] row_base;
    logic              row_end;

    assign row_end = col == w - 11'd1;
    assign last    = row_end && (row == h - 10'd1);
    assign address = row_base + ADDR_W'(x0) + ADDR_W'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (init) begin
            col      <= '0;
            row      <= '0;
            row_base <= ADDR_W'(y0) * ADDR_W'(H_RES);
        end else if (accept) begin
            col      <= row_end ? 11'd0 : col + 11'd1;
            row      <= row_end ? row + 10'd1 : row;
            row_base <= row_end ? row_base + ADDR_W'(H_RES) : row_base;
        end
    end
endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: Avalon-MM rectangle fill engine, one master write per pixel, row-major.
// Optional done interrupt (irq port, STATUS irq_en bit) when VGA_FILL_IRQ_EN is defined.
module vga_rect_fill
    import vga_fill_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              avs_s1_clk_iCLK,
    input  logic              avs_s1_reset_n_iRST_N,
    input  logic [2:0]        avs_s1_address,
    input  logic [DATA_W-1:0] avs_s1_writedata,
    output logic [DATA_W-1:0] avs_s1_readdata,
    input  logic              avs_s1_write,
    input  logic              avs_s1_read,
    input  logic              avs_s1_chipselect,
    output logic [ADDR_W-1:0] avm_m1_address,
    output logic [DATA_W-1:0] avm_m1_writedata,
    output logic              avm_m1_write,
    input  logic              avm_m1_waitrequest
`ifdef VGA_FILL_IRQ_EN
    ,
    output logic              irq
`endif
);
    state_t            state;
    logic [9:0]        x0_r, y0_r, h_r, wx0, wy0, wh;
    logic [10:0]       w_r, ww;
    logic [DATA_W-1:0] fill_r, wfill, rd_mux;
    logic              done, error, aborted, irq_en, abort_pend;
    logic              wr, rd, busy, accept, last, start_req, abort_req;

    assign wr               = avs_s1_chipselect & avs_s1_write;
    assign rd               = avs_s1_chipselect & avs_s1_read;
    assign start_req        = wr && avs_s1_address == REG_CTRL && avs_s1_writedata[CTRL_START];
    assign abort_req        = wr && avs_s1_address == REG_CTRL && avs_s1_writedata[CTRL_ABORT];
    assign busy             = state == CHECK || state == WRITE;
    assign accept           = avm_m1_write & ~avm_m1_waitrequest;
    assign avm_m1_writedata = wfill;

    assign rd_mux = avs_s1_address == REG_X0     ? DATA_W'(x0_r) :
                    avs_s1_address == REG_Y0     ? DATA_W'(y0_r) :
                    avs_s1_address == REG_W      ? DATA_W'(w_r) :
                    avs_s1_address == REG_H      ? DATA_W'(h_r) :
                    avs_s1_address == REG_FILL   ? fill_r :
                    avs_s1_address == REG_STATUS ? DATA_W'({irq_en, aborted, error, done, busy}) :
                    '0;

`ifndef VGA_FILL_IRQ_EN
    assign irq_en = 1'b0;
`endif

    vga_fill_addr_gen #(.H_RES(H_RES), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (avs_s1_clk_iCLK),
        .rst_n   (avs_s1_reset_n_iRST_N),
        .init    (state == CHECK),
        .accept  (accept),
        .x0      (wx0),
        .y0      (wy0),
        .w       (ww),
        .h       (wh),
        .address (avm_m1_address),
        .last    (last)
    );

    // Status clears come first so a DONE entry on the same edge wins.
    always_ff @(posedge avs_s1_clk_iCLK or negedge avs_s1_reset_n_iRST_N) begin
        if (!avs_s1_reset_n_iRST_N) begin
            state           <= IDLE;
            avs_s1_readdata <= '0;
            avm_m1_write    <= 1'b0;
            {x0_r, y0_r, h_r, wx0, wy0, wh} <= '0;
            {w_r, ww}       <= '0;
            {fill_r, wfill} <= '0;
            {done, error, aborted, abort_pend} <= '0;
`ifdef VGA_FILL_IRQ_EN
            irq_en <= 1'b0;
            irq    <= 1'b0;
`endif
        end else begin
            if (rd)
                avs_s1_readdata <= rd_mux;
            if (wr)
                case (avs_s1_address)
                    REG_X0:   x0_r   <= avs_s1_writedata[9:0];
                    REG_Y0:   y0_r   <= avs_s1_writedata[9:0];
                    REG_W:    w_r    <= avs_s1_writedata[10:0];
                    REG_H:    h_r    <= avs_s1_writedata[9:0];
                    REG_FILL: fill_r <= avs_s1_writedata;
                    REG_STATUS: begin
                        {done, error, aborted} <= '0;
`ifdef VGA_FILL_IRQ_EN
                        irq_en <= avs_s1_writedata[ST_IRQ_EN];
`endif
                    end
                    default: ;
                endcase
            if (abort_req && busy)
                abort_pend <= 1'b1;
            case (state)
                IDLE: if (start_req) begin
                    {wx0, wy0, ww, wh, wfill} <= {x0_r, y0_r, w_r, h_r, fill_r};
                    state <= CHECK;
                end
                CHECK: if (ww == 11'd0 || wh == 10'd0) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else if (12'(wx0) + 12'(ww) > 12'(H_RES) || 12'(wy0) + 12'(wh) > 12'(V_RES)) begin
                    done  <= 1'b1;
                    error <= 1'b1;
                    state <= DONE;
                end else begin
                    avm_m1_write <= 1'b1;
                    state        <= WRITE;
                end
                WRITE: if (accept && (last || abort_pend)) begin
                    avm_m1_write <= 1'b0;
                    done         <= 1'b1;
                    if (abort_pend)
                        aborted <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef VGA_FILL_IRQ_EN
            irq <= done & irq_en;
`endif
        end
    end
endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: randomized and directed fills checked against an address-list model.
module tb_vga_rect_fill;
    import vga_fill_pkg::*;
    localparam int H_RES = 640, V_RES = 480, ADDR_W = 19, DATA_W = 16;

    logic              clk = 0, rst_n = 0;
    logic [2:0]        s_addr = 0;
    logic [DATA_W-1:0] s_wdata = 0, s_rdata;
    logic              s_wr = 0, s_rd = 0, s_cs = 0;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wr, m_wait = 0;
`ifdef VGA_FILL_IRQ_EN
    logic              irq;
`endif

    int n_cmp = 0, n_bad = 0;
    int exp_q[$];
    int exp_n, acc_cnt = 0, wcyc_cnt = 0, first_acc = 0, last_acc = 0, cyc = 0, wmode = 0;
    logic [15:0] exp_fill = 0;
    logic exp_err = 0;
    logic prev_stall = 0;
    logic [ADDR_W-1:0] prev_addr = 0;
    logic [DATA_W-1:0] prev_data = 0;

    always #5 clk = ~clk;

    vga_rect_fill dut (
        .avs_s1_clk_iCLK       (clk),
        .avs_s1_reset_n_iRST_N (rst_n),
        .avs_s1_address        (s_addr),
        .avs_s1_writedata      (s_wdata),
        .avs_s1_readdata       (s_rdata),
        .avs_s1_write          (s_wr),
        .avs_s1_read           (s_rd),
        .avs_s1_chipselect     (s_cs),
        .avm_m1_address        (m_addr),
        .avm_m1_writedata      (m_wdata),
        .avm_m1_write          (m_wr),
        .avm_m1_waitrequest    (m_wait)
`ifdef VGA_FILL_IRQ_EN
        ,
        .irq                   (irq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // 0: never stall, 1: random stalls, 2: hold stalled
    initial forever begin
        @(posedge clk);
        #1;
        m_wait = wmode == 2 ? 1'b1 : wmode == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    always @(negedge clk) if (rst_n) begin
        if (prev_stall) begin
            chk("hold_write", m_wr, 1);
            chk("hold_addr", m_addr, prev_addr);
            chk("hold_data", m_wdata, prev_data);
        end
        if (m_wr) begin
            wcyc_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_write: got addr 0x%0h expected no write", m_addr);
            end else begin
                chk("wr_addr", m_addr, exp_q[0]);
                chk("wr_data", m_wdata, exp_fill);
                if (!m_wait) void'(exp_q.pop_front());
            end
            if (!m_wait) begin
                acc_cnt++;
                if (acc_cnt == 1) first_acc = cyc;
                last_acc = cyc;
            end
        end
        prev_stall = m_wr && m_wait;
        prev_addr  = m_addr;
        prev_data  = m_wdata;
    end

    task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        s_cs = 1; s_wr = 1; s_addr = a; s_wdata = d;
        @(posedge clk); #1;
        s_cs = 0; s_wr = 0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        s_cs = 1; s_rd = 1; s_addr = a;
        @(posedge clk); #1;
        s_cs = 0; s_rd = 0;
        d = s_rdata;
    endtask

    task automatic model_fill(input int x0, input int y0, input int w, input int h, input logic [15:0] f);
        exp_q.delete();
        exp_fill = f;
        exp_err  = w != 0 && h != 0 && (x0 + w > H_RES || y0 + h > V_RES);
        if (w != 0 && h != 0 && !exp_err)
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    exp_q.push_back((y0 + r) * H_RES + x0 + c);
        exp_n    = exp_q.size();
        acc_cnt  = 0;
        wcyc_cnt = 0;
        reg_wr(REG_X0, 16'(x0));
        reg_wr(REG_Y0, 16'(y0));
        reg_wr(REG_W, 16'(w));
        reg_wr(REG_H, 16'(h));
        reg_wr(REG_FILL, f);
    endtask

    task automatic wait_idle(input string name);
        logic [15:0] s;
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            reg_rd(REG_STATUS, s);
            ok = !s[ST_BUSY];
        end
        chk({name, "_idle"}, 32'(ok), 1);
    endtask

    task automatic finish_fill(input string name, input int n, input logic [15:0] st);
        logic [15:0] s;
        wait_idle(name);
        chk({name, "_accepts"}, acc_cnt, n);
        reg_rd(REG_STATUS, s);
        chk({name, "_status"}, s, st);
        reg_wr(REG_STATUS, 16'h0);
    endtask

    initial begin
        logic [15:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", m_wr, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rdata", s_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        reg_rd(REG_STATUS, d);
        chk("rst_status", d, 0);

        reg_wr(REG_X0, 16'hFFFF);
        reg_wr(REG_W, 16'hFFFF);
        reg_wr(REG_FILL, 16'hA5C3);
        reg_rd(REG_X0, d);      chk("rb_x0", d, 16'h03FF);
        reg_rd(REG_W, d);       chk("rb_w", d, 16'h07FF);
        reg_rd(REG_FILL, d);    chk("rb_fill", d, 16'hA5C3);
        reg_rd(REG_CTRL, d);    chk("rb_ctrl", d, 0);
        reg_rd(3'd7, d);        chk("rb_unmapped", d, 0);

        model_fill(0, 0, 4, 2, 16'hF800);
        chk("pin_t1_a4", exp_q[4], 640);
        reg_wr(REG_CTRL, 16'h1);
        finish_fill("t1", 8, 16'h0002);
        chk("t1_span", last_acc - first_acc, 7);
        chk("t1_wcycles", wcyc_cnt, 8);

        wmode = 1;
        model_fill(636, 479, 4, 1, 16'h07E0);
        chk("pin_t2_first", exp_q[0], 307196);
        chk("pin_t2_last", exp_q[3], 307199);
        reg_wr(REG_CTRL, 16'h1);
        finish_fill("t2", 4, 16'h0002);
        wmode = 0;

        model_fill(637, 0, 4, 1, 16'h1111);
        reg_wr(REG_CTRL, 16'h1);
        finish_fill("t3", 0, 16'h0006);
        chk("t3_wcycles", wcyc_cnt, 0);

        model_fill(10, 10, 0, 5, 16'h2222);
        reg_wr(REG_CTRL, 16'h1);
        finish_fill("t4", 0, 16'h0002);
        chk("t4_wcycles", wcyc_cnt, 0);

        model_fill(5, 5, 10, 10, 16'h3C3C);
        reg_wr(REG_CTRL, 16'h1);
        for (int i = 0; i < 500 && acc_cnt < 7; i++) @(posedge clk);
        wmode = 2;
        chk("t5_reach7", acc_cnt, 7);
        reg_wr(REG_FILL, 16'hDEAD);
        reg_wr(REG_CTRL, 16'h1);
        reg_wr(REG_CTRL, 16'h2);
        repeat (3) @(posedge clk);
        wmode = 0;
        finish_fill("t5", 8, 16'h000A);
        chk("t5_left", exp_q.size(), 92);

        for (int t = 0; t < 12; t++) begin
            int x0, y0, w, h;
            x0 = $urandom_range(0, 3) == 0 ? $urandom_range(630, 639) : $urandom_range(0, 639);
            y0 = $urandom_range(0, 3) == 0 ? $urandom_range(474, 479) : $urandom_range(0, 479);
            w  = $urandom_range(0, 9);
            h  = $urandom_range(0, 5);
            wmode = $urandom_range(0, 1);
            model_fill(x0, y0, w, h, 16'($urandom));
            reg_wr(REG_CTRL, 16'h1);
            finish_fill("rnd", exp_n, exp_err ? 16'h0006 : 16'h0002);
            chk("rnd_left", exp_q.size(), 0);
        end
        wmode = 0;

`ifdef VGA_FILL_IRQ_EN
        reg_wr(REG_STATUS, 16'h0010);
        model_fill(1, 1, 1, 1, 16'h5555);
        reg_wr(REG_CTRL, 16'h1);
        for (int i = 0; i < 100 && !irq; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_irq_rise", irq, 1);
        wait_idle("t6");
        reg_rd(REG_STATUS, d);
        chk("t6_status", d, 16'h0012);
        reg_wr(REG_STATUS, 16'h0010);
        chk("t6_irq_lag", irq, 1);
        @(posedge clk); #1;
        chk("t6_irq_drop", irq, 0);
        reg_wr(REG_STATUS, 16'h0);
`else
        reg_wr(REG_STATUS, 16'h0010);
        reg_rd(REG_STATUS, d);
        chk("no_irq_en", d, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
